// File: rtl/bit_stream_fifo.sv
// bit_stream_fifo: bit-granular FIFO taking IN_WIDTH-bit words and returning LSB-first bit fields.
// Ports:
//   clock    - rising-edge clock
//   reset    - asynchronous active-low reset; clears all state and outputs
//   pushin   - write strobe for datain; word is dropped (overflow set) when full
//   datain   - word appended to the bit stream
//   full     - all DEPTH slots occupied, a partially consumed head word included
//   overflow - sticky flag, set when a push is dropped
//   reqin    - field request strobe
//   reqlen   - requested field length in bits
//   pushout  - one-cycle response strobe, one per request
//   lenout   - valid bits in dataout: min(reqlen, OUT_MAX, bitcount)
//   dataout  - returned field, LSB-aligned, zero above lenout
//   bitcount - unconsumed bits currently stored
module bit_stream_fifo #(
    parameter  int IN_WIDTH  = 32,
    parameter  int DEPTH     = 32,
    parameter  int OUT_MAX   = 15,
    parameter  int LEN_WIDTH = 4,
    localparam int CNT_WIDTH = $clog2(IN_WIDTH * DEPTH) + 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 pushin,
    input  logic [IN_WIDTH-1:0]  datain,
    output logic                 full,
    output logic                 overflow,
    input  logic                 reqin,
    input  logic [LEN_WIDTH-1:0] reqlen,
    output logic                 pushout,
    output logic [LEN_WIDTH-1:0] lenout,
    output logic [OUT_MAX-1:0]   dataout,
    output logic [CNT_WIDTH-1:0] bitcount
);
    localparam int AW = $clog2(DEPTH);
    localparam int OW = $clog2(IN_WIDTH);
    localparam int PW = AW + OW;
    localparam int MW = OUT_MAX + 1;

    logic [IN_WIDTH-1:0]  mem [DEPTH];
    logic [AW-1:0]        wr_ptr, wr_next, rd_word, nx_word;
    // read position in bits: upper AW bits are the word index, lower OW bits the offset,
    // so advancing by a field length wraps both naturally around the ring
    logic [PW-1:0]        rd_pos, rd_pos_next;
    logic [OW-1:0]        rd_off;
    logic                 push_ok, full_next;
    logic [31:0]          req_c, take;
    logic [OUT_MAX-1:0]   window, mask, field;
    logic [CNT_WIDTH-1:0] count_next;

    always_comb begin
        rd_word     = rd_pos[PW-1:OW];
        rd_off      = rd_pos[OW-1:0];
        nx_word     = rd_word + AW'(1);
        // full is the registered value, so a push is judged before this cycle's read
        push_ok     = pushin && !full;
        req_c       = 32'(reqlen) > 32'(OUT_MAX) ? 32'(OUT_MAX) : 32'(reqlen);
        take        = !reqin ? 32'd0 : (req_c > 32'(bitcount) ? 32'(bitcount) : req_c);
        // the field may straddle the head word and its successor; bits beyond
        // bitcount are masked off, so stale slot contents never leak out
        window      = OUT_MAX'({mem[nx_word], mem[rd_word]} >> rd_off);
        mask        = OUT_MAX'((MW'(1) << take) - MW'(1));
        field       = window & mask;
        rd_pos_next = rd_pos + PW'(take);
        wr_next     = push_ok ? wr_ptr + AW'(1) : wr_ptr;
        count_next  = bitcount - CNT_WIDTH'(take) + (push_ok ? CNT_WIDTH'(IN_WIDTH) : '0);
        // equal word indices with data present means the writer has lapped the reader
        full_next   = (wr_next == rd_pos_next[PW-1:OW]) && (count_next != '0);
    end

    always_ff @(posedge clock)
        if (push_ok) mem[wr_ptr] <= datain;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_pos   <= '0;
            bitcount <= '0;
            full     <= 1'b0;
            overflow <= 1'b0;
            pushout  <= 1'b0;
            lenout   <= '0;
            dataout  <= '0;
        end else begin
            wr_ptr   <= wr_next;
            rd_pos   <= rd_pos_next;
            bitcount <= count_next;
            full     <= full_next;
            overflow <= overflow | (pushin & full);
            pushout  <= reqin;
            if (reqin) begin
                lenout  <= LEN_WIDTH'(take);
                dataout <= field;
            end
        end
    end
endmodule

// File: tb/tb_bit_stream_fifo.sv
// tb_bit_stream_fifo: randomized and directed checks of bit_stream_fifo against a bit-queue model.
module tb_bit_stream_fifo;
    logic        clock = 0, reset = 0, pushin = 0, reqin = 0;
    logic [31:0] datain = 0;
    logic [3:0]  reqlen = 0;
    logic        full, overflow, pushout;
    logic [3:0]  lenout;
    logic [14:0] dataout;
    logic [10:0] bitcount;
    logic        full8, ovf8, push8;
    logic [3:0]  len8;
    logic [7:0]  data8;
    logic [10:0] cnt8;

    bit          q[$];
    int          off_m, vectors, errors;
    bit          ovf_m, epush;
    logic [3:0]  elen;
    logic [14:0] edata;

    always #5 clock = ~clock;

    bit_stream_fifo dut (
        .clock(clock), .reset(reset), .pushin(pushin), .datain(datain), .full(full),
        .overflow(overflow), .reqin(reqin), .reqlen(reqlen), .pushout(pushout),
        .lenout(lenout), .dataout(dataout), .bitcount(bitcount)
    );

    bit_stream_fifo #(.OUT_MAX(8)) dut8 (
        .clock(clock), .reset(reset), .pushin(pushin), .datain(datain), .full(full8),
        .overflow(ovf8), .reqin(reqin), .reqlen(reqlen), .pushout(push8),
        .lenout(len8), .dataout(data8), .bitcount(cnt8)
    );

    // occupied slots = stored bits plus the consumed part of the head word, rounded up to words
    function automatic bit full_m();
        return ((q.size() + off_m + 31) / 32) == 32;
    endfunction

    function automatic logic [32:0] obs();
        return {pushout, lenout, dataout, bitcount, full, overflow};
    endfunction

    function automatic logic [32:0] expv();
        return {epush, elen, edata, 11'(q.size()), full_m(), ovf_m};
    endfunction

    task automatic model_clear();
        q.delete();
        off_m = 0; ovf_m = 0; epush = 0; elen = 0; edata = 0;
    endtask

    task automatic do_reset();
        @(posedge clock); #1;
        reset = 0; pushin = 0; reqin = 0;
        #3 reset = 1;
        model_clear();
    endtask

    task automatic step(input bit p, input logic [31:0] d, input bit r, input int len);
        int  l;
        bit  acc;
        pushin = p; datain = d; reqin = r; reqlen = 4'(len);
        @(posedge clock); #1;
        pushin = 0; reqin = 0;
        acc = p && !full_m();
        if (p && !acc) ovf_m = 1;
        epush = r;
        if (r) begin
            l = len > 15 ? 15 : len;
            if (l > q.size()) l = q.size();
            edata = '0;
            for (int i = 0; i < l; i++) edata[i] = q.pop_front();
            elen = 4'(l);
            off_m = (off_m + l) % 32;
        end
        if (acc) for (int i = 0; i < 32; i++) q.push_back(d[i]);
    endtask

    task automatic test_reset();
        do_reset();
        step(0, 0, 0, 0);
        vectors++;
        if (obs() !== 33'd0) begin
            errors++; $display("FAIL reset_state: got %h want %h", obs(), 33'd0);
        end
    endtask

    task automatic test_single_word();
        int lens[2] = '{4, 12};
        logic [18:0] want[2] = '{{4'd4, 15'h000F}, {4'd12, 15'h0BEE}};
        do_reset();
        step(1, 32'hDEADBEEF, 0, 0);
        for (int i = 0; i < 2; i++) begin
            step(0, 0, 1, lens[i]);
            vectors++;
            if (obs() !== expv()) begin
                errors++; $display("FAIL single_word[%0d]: got %h want %h", i, obs(), expv());
            end
            vectors++;
            if ({lenout, dataout} !== want[i]) begin
                errors++; $display("FAIL single_word_const[%0d]: got %h want %h", i, {lenout, dataout}, want[i]);
            end
        end
    endtask

    task automatic test_span();
        do_reset();
        step(1, 32'hDEADBEEF, 0, 0);
        step(1, 32'h12345678, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 1, 15);
            vectors++;
            if (obs() !== expv()) begin
                errors++; $display("FAIL span[%0d]: got %h want %h", i, obs(), expv());
            end
        end
        vectors++;
        if ({dataout, bitcount} !== {15'h59E3, 11'd19}) begin
            errors++; $display("FAIL span_const: got %h want %h", {dataout, bitcount}, {15'h59E3, 11'd19});
        end
    endtask

    task automatic test_short_reads();
        do_reset();
        step(1, 32'h0000000A, 0, 0);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 1, 15);
            vectors++;
            if (obs() !== expv()) begin
                errors++; $display("FAIL short_read[%0d]: got %h want %h", i, obs(), expv());
            end
        end
        vectors++;
        if ({pushout, lenout, dataout, bitcount} !== 31'({1'b1, 4'd0, 15'd0, 11'd0})) begin
            errors++; $display("FAIL short_read_zero: got %h want %h", {pushout, lenout, dataout, bitcount}, 31'h40000000);
        end
    endtask

    task automatic test_full_overflow();
        int lens[3] = '{15, 15, 2};
        do_reset();
        for (int i = 0; i < 32; i++) step(1, $urandom, 0, 0);
        vectors++;
        if ({full, overflow, bitcount} !== {1'b1, 1'b0, 11'd1024}) begin
            errors++; $display("FAIL full_set: got %h want %h", {full, overflow, bitcount}, {1'b1, 1'b0, 11'd1024});
        end
        step(1, $urandom, 0, 0);
        vectors++;
        if (obs() !== expv() || !overflow) begin
            errors++; $display("FAIL overflow_drop: got %h want %h", obs(), expv());
        end
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 1, lens[i]);
            vectors++;
            if (obs() !== expv()) begin
                errors++; $display("FAIL drain[%0d]: got %h want %h", i, obs(), expv());
            end
        end
        step(1, $urandom, 0, 0);
        vectors++;
        if (obs() !== expv()) begin
            errors++; $display("FAIL push_after_full: got %h want %h", obs(), expv());
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        step(1, $urandom, 0, 0);
        step(0, 0, 1, 15);
        step(0, 0, 1, 12);
        step(1, $urandom, 1, 15);
        vectors++;
        if (obs() !== expv() || {lenout, bitcount} !== {4'd5, 11'd32}) begin
            errors++; $display("FAIL simultaneous: got %h want %h", obs(), expv());
        end
    endtask

    task automatic test_clamp();
        logic [31:0] w;
        w = $urandom;
        do_reset();
        step(1, w, 0, 0);
        step(0, 0, 1, 15);
        vectors++;
        if ({push8, len8, data8, cnt8} !== {1'b1, 4'd8, w[7:0], 11'd24}) begin
            errors++; $display("FAIL clamp8: got %h want %h", {push8, len8, data8, cnt8}, {1'b1, 4'd8, w[7:0], 11'd24});
        end
        vectors++;
        if (obs() !== expv()) begin
            errors++; $display("FAIL clamp15: got %h want %h", obs(), expv());
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            step(($urandom % 10) < ((i / 150) % 2 == 0 ? 6 : 1), $urandom,
                 ($urandom % 10) < 7, int'($urandom % 16));
            vectors++;
            if (obs() !== expv()) begin
                errors++; $display("FAIL random[%0d]: got %h want %h", i, obs(), expv());
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 32; i++) step(1, $urandom, 0, 0);
        step(0, 0, 1, 15);
        vectors++;
        if (!(pushout && full) || obs() !== expv()) begin
            errors++; $display("FAIL pre_async: got %h want %h", obs(), expv());
        end
        #2 reset = 0;
        #1;
        vectors++;
        if (obs() !== 33'd0) begin
            errors++; $display("FAIL async_clear: got %h want %h", obs(), 33'd0);
        end
        reset = 1;
        model_clear();
        step(0, 0, 0, 0);
        vectors++;
        if (obs() !== expv()) begin
            errors++; $display("FAIL no_stale_pushout: got %h want %h", obs(), expv());
        end
        step(0, 0, 1, 4);
        vectors++;
        if (obs() !== expv() || {pushout, lenout, dataout} !== 20'h80000) begin
            errors++; $display("FAIL empty_request: got %h want %h", obs(), expv());
        end
    endtask

    initial begin
        vectors = 0;
        errors  = 0;
        model_clear();
        test_reset();
        test_single_word();
        test_span();
        test_short_reads();
        test_full_overflow();
        test_simultaneous();
        test_clamp();
        test_random();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
